// File: rtl/ddc_cic_dec_param_if.sv
// Sample/config/output bundle for the single-clock DDC + CIC decimator.
// master drives samples and config; slave is the DDC.
interface ddc_cic_dec_param_if #(
  parameter int W_IN  = 16,
  parameter int W_OUT = 20,
  parameter int W_R   = 6,
  parameter int W_SH  = 6
);
  logic                    in_valid;
  logic signed [W_IN-1:0]  get_i;
  logic signed [W_IN-1:0]  get_q;
  logic signed [W_IN-1:0]  sig_in_i;
  logic signed [W_IN-1:0]  sig_in_q;
  logic                    cfg_load;
  logic [W_R-1:0]          dec_ratio;
  logic [W_SH-1:0]         shift;
  logic                    bypass;
  logic signed [W_OUT-1:0] sig_out_i;
  logic signed [W_OUT-1:0] sig_out_q;
  logic                    out_valid;
  logic                    ovf;

  modport master (
    output in_valid, get_i, get_q, sig_in_i, sig_in_q,
    output cfg_load, dec_ratio, shift, bypass,
    input  sig_out_i, sig_out_q, out_valid, ovf
  );

  modport slave (
    input  in_valid, get_i, get_q, sig_in_i, sig_in_q,
    input  cfg_load, dec_ratio, shift, bypass,
    output sig_out_i, sig_out_q, out_valid, ovf
  );
endinterface

// File: rtl/ddc_cic_dec_param.sv
// Complex mixer followed by an ORDER-stage CIC decimator.
// Runtime ratio, output shift, saturation and bypass.
module ddc_cic_dec_param #(
  parameter int W_IN  = 16,
  parameter int W_OUT = 20,
  parameter int ORDER = 5,
  parameter int R_MAX = 32,
  parameter int W_R   = 6,
  parameter int W_SH  = 6
) (
  input logic clk,
  input logic reset,
  ddc_cic_dec_param_if.slave bus
);
  localparam int W_LR  = $clog2(R_MAX);
  localparam int W_ACC = W_IN + ORDER * W_LR;
  localparam int W_P   = 2 * W_IN + 1;
  localparam logic signed [W_IN-1:0] MAX_IN =
    {1'b0, {(W_IN-1){1'b1}}};
  localparam logic signed [W_IN-1:0] MIN_IN =
    {1'b1, {(W_IN-1){1'b0}}};
  localparam logic signed [W_OUT-1:0] MAX_OUT =
    {1'b0, {(W_OUT-1){1'b1}}};
  localparam logic signed [W_OUT-1:0] MIN_OUT =
    {1'b1, {(W_OUT-1){1'b0}}};

  logic [W_R-1:0]  ratio_r, ratio_n;
  logic [W_SH-1:0] sh_r;
  logic            bp_r;

  logic signed [W_P-1:0] pi_f, pq_f, pi_s, pq_s;
  logic                  sat_pi, sat_pq;
  logic signed [W_IN-1:0] mi_n, mq_n, mix_i, mix_q;
  logic                   mix_v;

  logic signed [W_ACC-1:0] int_i [ORDER];
  logic signed [W_ACC-1:0] int_q [ORDER];
  logic signed [W_ACC-1:0] ii_in [ORDER];
  logic signed [W_ACC-1:0] iq_in [ORDER];
  logic [ORDER-1:0]        int_v, iv_in;

  logic [W_R-1:0]          cnt;
  logic signed [W_ACC-1:0] dec_i, dec_q;
  logic                    dec_v;

  logic signed [W_ACC-1:0] comb_i [ORDER];
  logic signed [W_ACC-1:0] comb_q [ORDER];
  logic signed [W_ACC-1:0] dly_i  [ORDER];
  logic signed [W_ACC-1:0] dly_q  [ORDER];
  logic signed [W_ACC-1:0] ci_in  [ORDER];
  logic signed [W_ACC-1:0] cq_in  [ORDER];
  logic [ORDER-1:0]        comb_v, cv_in;

  logic signed [W_ACC-1:0] oi_s, oq_s;
  logic                    sat_oi, sat_oq;
  logic signed [W_OUT-1:0] oi_n, oq_n, out_i, out_q;
  logic                    out_v, ovf_r, cic_out;

  always_comb begin
    ratio_n = bus.dec_ratio;
    if (bus.dec_ratio < W_R'(2))
      ratio_n = W_R'(2);
    else if (bus.dec_ratio > W_R'(R_MAX))
      ratio_n = W_R'(R_MAX);
  end

  // Full-precision complex product, floor-scaled, then clipped to W_IN
  always_comb begin
    pi_f = W_P'(bus.get_i) * W_P'(bus.sig_in_i)
         - W_P'(bus.get_q) * W_P'(bus.sig_in_q);
    pq_f = W_P'(bus.get_i) * W_P'(bus.sig_in_q)
         + W_P'(bus.get_q) * W_P'(bus.sig_in_i);
    pi_s = pi_f >>> (W_IN - 1);
    pq_s = pq_f >>> (W_IN - 1);
    sat_pi = ~((&pi_s[W_P-1:W_IN-1]) | ~(|pi_s[W_P-1:W_IN-1]));
    sat_pq = ~((&pq_s[W_P-1:W_IN-1]) | ~(|pq_s[W_P-1:W_IN-1]));
    mi_n = pi_s[W_IN-1:0];
    mq_n = pq_s[W_IN-1:0];
    if (sat_pi) mi_n = pi_s[W_P-1] ? MIN_IN : MAX_IN;
    if (sat_pq) mq_n = pq_s[W_P-1] ? MIN_IN : MAX_IN;
  end

  always_comb begin
    ii_in[0] = W_ACC'(mix_i);
    iq_in[0] = W_ACC'(mix_q);
    iv_in[0] = mix_v;
    ci_in[0] = dec_i;
    cq_in[0] = dec_q;
    cv_in[0] = dec_v;
    for (int k = 1; k < ORDER; k++) begin
      ii_in[k] = int_i[k-1];
      iq_in[k] = int_q[k-1];
      iv_in[k] = int_v[k-1];
      ci_in[k] = comb_i[k-1];
      cq_in[k] = comb_q[k-1];
      cv_in[k] = comb_v[k-1];
    end
  end

  always_comb begin
    oi_s = comb_i[ORDER-1] >>> sh_r;
    oq_s = comb_q[ORDER-1] >>> sh_r;
    sat_oi = ~((&oi_s[W_ACC-1:W_OUT-1]) | ~(|oi_s[W_ACC-1:W_OUT-1]));
    sat_oq = ~((&oq_s[W_ACC-1:W_OUT-1]) | ~(|oq_s[W_ACC-1:W_OUT-1]));
    oi_n = oi_s[W_OUT-1:0];
    oq_n = oq_s[W_OUT-1:0];
    if (sat_oi) oi_n = oi_s[W_ACC-1] ? MIN_OUT : MAX_OUT;
    if (sat_oq) oq_n = oq_s[W_ACC-1] ? MIN_OUT : MAX_OUT;
    cic_out = ~bp_r & comb_v[ORDER-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ratio_r <= W_R'(2);
      sh_r    <= '0;
      bp_r    <= 1'b0;
    end else if (bus.cfg_load) begin
      ratio_r <= ratio_n;
      sh_r    <= bus.shift;
      bp_r    <= bus.bypass;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mix_v <= 1'b0;
      mix_i <= '0;
      mix_q <= '0;
    end else if (bus.cfg_load) begin
      mix_v <= 1'b0;
    end else begin
      mix_v <= bus.in_valid;
      if (bus.in_valid) begin
        mix_i <= mi_n;
        mix_q <= mq_n;
      end
    end
  end

  // Integrators wrap freely; the combs undo the wrap exactly
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      int_v <= '0;
      for (int k = 0; k < ORDER; k++) begin
        int_i[k] <= '0;
        int_q[k] <= '0;
      end
    end else if (bus.cfg_load) begin
      int_v <= '0;
      for (int k = 0; k < ORDER; k++) begin
        int_i[k] <= '0;
        int_q[k] <= '0;
      end
    end else begin
      int_v <= iv_in;
      for (int k = 0; k < ORDER; k++) begin
        if (iv_in[k]) begin
          int_i[k] <= int_i[k] + ii_in[k];
          int_q[k] <= int_q[k] + iq_in[k];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      dec_v <= 1'b0;
      dec_i <= '0;
      dec_q <= '0;
    end else if (bus.cfg_load) begin
      cnt   <= '0;
      dec_v <= 1'b0;
      dec_i <= '0;
      dec_q <= '0;
    end else begin
      dec_v <= 1'b0;
      if (int_v[ORDER-1]) begin
        if (cnt == ratio_r - W_R'(1)) begin
          cnt   <= '0;
          dec_v <= 1'b1;
          dec_i <= int_i[ORDER-1];
          dec_q <= int_q[ORDER-1];
        end else begin
          cnt <= cnt + W_R'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      comb_v <= '0;
      for (int k = 0; k < ORDER; k++) begin
        comb_i[k] <= '0;
        comb_q[k] <= '0;
        dly_i[k]  <= '0;
        dly_q[k]  <= '0;
      end
    end else if (bus.cfg_load) begin
      comb_v <= '0;
      for (int k = 0; k < ORDER; k++) begin
        comb_i[k] <= '0;
        comb_q[k] <= '0;
        dly_i[k]  <= '0;
        dly_q[k]  <= '0;
      end
    end else begin
      comb_v <= cv_in;
      for (int k = 0; k < ORDER; k++) begin
        if (cv_in[k]) begin
          comb_i[k] <= ci_in[k] - dly_i[k];
          comb_q[k] <= cq_in[k] - dly_q[k];
          dly_i[k]  <= ci_in[k];
          dly_q[k]  <= cq_in[k];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_v <= 1'b0;
      out_i <= '0;
      out_q <= '0;
      ovf_r <= 1'b0;
    end else if (bus.cfg_load) begin
      out_v <= 1'b0;
      ovf_r <= 1'b0;
    end else begin
      out_v <= bp_r ? mix_v : comb_v[ORDER-1];
      ovf_r <= ovf_r
             | (bus.in_valid & (sat_pi | sat_pq))
             | (cic_out & (sat_oi | sat_oq));
      if (bp_r & mix_v) begin
        out_i <= W_OUT'(mix_i) <<< (W_OUT - W_IN);
        out_q <= W_OUT'(mix_q) <<< (W_OUT - W_IN);
      end else if (cic_out) begin
        out_i <= oi_n;
        out_q <= oq_n;
      end
    end
  end

  assign bus.out_valid = out_v;
  assign bus.sig_out_i = out_i;
  assign bus.sig_out_q = out_q;
  assign bus.ovf       = ovf_r;
endmodule
